game_ctrl: RTL and testbench
============================

# game_ctrl

Top-level sequencer for the 4x4 2048 tile board. It accepts one-hot move commands from the input front-end and holds the corresponding board-wide ready line until the tile network settles. It then detects whether the move changed the board and, if so, spawns a new tile through the board's preset port. It also clears the board on new game, and flags win and game-over for the display/status logic.

## Interface
- SETTLE_CYCLES, 6, cycles the move request is held on the board (≥4 required by the 4-cell chain depth)
- LFSR_SEED, 16'hACE1, nonzero reset value of the spawn LFSR
- WIN_VALUE, 4'd11, log2 tile value that sets win (11 = tile 2048)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- new_game  input  1  one-cycle request to clear the board and restart
- move_valid  input  1  move request
- move_dir  input  2  direction index k; drives ready_to_board bit k
- move_ready  output  1  high only in IDLE; move accepted on move_valid && move_ready
- board_state  input  64  total_current_state of the board; cell i = [4i+3:4i], row i/4, col i%4, 0 = empty
- ready_to_board  output  4  to ready_from_global; one-hot during MOVE, else 0
- preset_ext  output  1  board preset strobe
- preset_location  output  4  preset cell index
- value_from_preset  output  4  preset value
- busy  output  1  high in any state except IDLE and OVER
- moved  output  1  one-cycle pulse when a move changed the board
- win  output  1  sticky; set when any cell ≥ WIN_VALUE
- game_over  output  1  high in OVER

## Operation
- States: CLEAR, SPAWN, SPAWN_WAIT, CHECK, IDLE, MOVE, COMPARE, OVER.
- Reset (rst=0 at a clock edge) sets:
  - state CLEAR, clr_cnt 0, spawn_cnt 0, settle counter 0, LFSR to LFSR_SEED, win 0.
  - All outputs 0 except busy=1.
- CLEAR: preset_ext=1, preset_location=clr_cnt, value_from_preset=0 for 16 cycles (locations 0..15). Then spawn_cnt←0 and go to SPAWN.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle outside reset.
- SPAWN entry: latch start=lfsr[3:0] and val = (lfsr[7:4]==0) ? 2 : 1. Probe counter k←0.
- SPAWN, each cycle probes cell c=(start+k) mod 16:
  - If board_state cell c == 0: preset_ext=1, location=c, value=val for this one cycle, then go to SPAWN_WAIT.
  - Else k++. If 16 probes find no empty cell, go to CHECK without presetting.
- SPAWN_WAIT: one cycle so board_state reflects the preset. Then spawn_cnt++. If the spawn was part of new-game initialisation and spawn_cnt<2, return to SPAWN; else go to CHECK.
- CHECK, one cycle:
  - win←1 if any cell ≥ WIN_VALUE.
  - If no cell is 0 and no orthogonally adjacent pair is equal (i,i+1 in the same row; i,i+4), go to OVER; else go to IDLE.
- IDLE:
  - new_game has priority over move_valid in the same cycle and goes to CLEAR.
  - On an accepted move: snapshot←board_state, dir latched, go to MOVE.
- MOVE: ready_to_board = 1<<dir for exactly SETTLE_CYCLES cycles, then go to COMPARE.
- COMPARE (ready_to_board=0):
  - If board_state ≠ snapshot: moved=1 this cycle, spawn_cnt←1, go to SPAWN.
  - Else go to IDLE.
- OVER: move_valid is ignored. new_game goes to CLEAR.
- win is cleared only by reset or by entering CLEAR. Play continues after win.
- new_game outside IDLE/OVER is ignored.

## Timing
- Move accepted at edge T:
  - ready_to_board is one-hot for cycles T+1..T+SETTLE_CYCLES.
  - COMPARE occurs at cycle T+SETTLE_CYCLES+1.
- Unchanged move: move_ready returns high at cycle T+SETTLE_CYCLES+2.
- Changed move: the spawn adds 1..16 probe cycles, plus 1 SPAWN_WAIT cycle, plus 1 CHECK cycle.
- Power-up / new game: 16 CLEAR cycles + 2 spawns, each (probes + wait), + 1 CHECK cycle.
- preset_ext is never high for more than one cycle outside CLEAR.
- ready_to_board and preset_ext are never high in the same cycle.
- Reset mid-operation: all outputs drop at the next edge and the CLEAR sequence restarts.

## Test plan
- Reset: rst=0 for 2 cycles, then release → preset_ext high for 16 consecutive cycles with location 0..15, value 0. Then exactly 2 single-cycle presets at distinct locations, values ∈{1,2}. Then move_ready=1 and game_over=0.
- Changed move (SETTLE_CYCLES=6), move_dir=2, bench board model alters state → ready_to_board=4'b0100 for exactly 6 cycles, moved pulses once, exactly 1 preset into a cell that was 0.
- Unchanged move: board_state constant → no moved pulse, no preset, move_ready low for exactly 7 cycles.
- Game over: post-move board has only cell 5 empty; cells 1,4,6,9 = 4'd3; the rest is a pattern with no equal orthogonal pairs → spawn at location 5, game_over=1, further move_valid ignored. Then new_game → CLEAR and game_over=0.
- Win: post-move board contains 4'd11 → win=1 after CHECK and stays 1 across later moves. new_game clears it.
- Reset mid-move: rst=0 in the 3rd MOVE cycle → ready_to_board=0 at the next edge, CLEAR restarts at location 0.

Source files
------------

// File: rtl/game_ctrl.sv
// game_ctrl: move/spawn/clear sequencer for the 4x4 2048 tile board.
// Outputs are registered. move_ready, busy, game_over and ready_to_board are
// decoded from the next state so they line up with the state they describe;
// preset, moved and win come from decisions made in the current state and so
// appear one cycle after that decision.
module game_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 6,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic [3:0]  WIN_VALUE     = 4'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_game,
   input  logic        move_valid,
   input  logic [1:0]  move_dir,
   output logic        move_ready,
   input  logic [63:0] board_state,
   output logic [3:0]  ready_to_board,
   output logic        preset_ext,
   output logic [3:0]  preset_location,
   output logic [3:0]  value_from_preset,
   output logic        busy,
   output logic        moved,
   output logic        win,
   output logic        game_over
);

   localparam int unsigned CELLS = 16;
   localparam int unsigned CW    = 4;
   localparam int unsigned SW    = $clog2(SETTLE_CYCLES);

   typedef enum logic [2:0] {
      CLEAR, SPAWN, SPAWN_WAIT, CHECK, IDLE, MOVE, COMPARE, OVER
   } state_t;

   state_t        state, state_n;
   logic [3:0]    clr_cnt, clr_cnt_n;
   logic [1:0]    spawn_cnt, spawn_cnt_n;
   logic [SW-1:0] settle_cnt, settle_n;
   logic [15:0]   lfsr, lfsr_n;
   logic [3:0]    start, start_n;
   logic [3:0]    val, val_n;
   logic [3:0]    probe, probe_n;
   logic [63:0]   snapshot, snapshot_n;
   logic [1:0]    dir, dir_n;
   logic          win_n;
   logic          move_ready_n, busy_n, moved_n, game_over_n;
   logic [3:0]    ready_n;
   logic          preset_ext_n;
   logic [3:0]    preset_loc_n, preset_val_n;
   logic          spawn_entry;

   logic          any_zero, any_win, any_pair;
   logic [3:0]    probe_loc;
   logic [3:0]    probe_cell;

   // Spawn LFSR feedback: Fibonacci, taps 16,14,13,11
   assign lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

   // Cell currently probed for an empty slot (wraps modulo 16)
   assign probe_loc  = start + probe;
   assign probe_cell = board_state[{probe_loc, 2'b00} +: CW];

   // Board status: empty cell present, win tile present, mergeable neighbours
   always_comb begin
      any_zero = 1'b0;
      any_win  = 1'b0;
      any_pair = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (board_state[CW*i +: CW] == 4'd0)      any_zero = 1'b1;
         if (board_state[CW*i +: CW] >= WIN_VALUE) any_win  = 1'b1;
      end
      for (int i = 0; i < 12; i++) begin
         if (board_state[CW*i +: CW] == board_state[CW*(i+4) +: CW]) any_pair = 1'b1;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (board_state[CW*(4*r+c) +: CW] == board_state[CW*(4*r+c+1) +: CW])
               any_pair = 1'b1;
         end
      end
   end

   // Next-state, counter and output decode
   always_comb begin
      state_n      = state;
      clr_cnt_n    = clr_cnt;
      spawn_cnt_n  = spawn_cnt;
      settle_n     = settle_cnt;
      start_n      = start;
      val_n        = val;
      probe_n      = probe;
      snapshot_n   = snapshot;
      dir_n        = dir;
      win_n        = win;
      preset_ext_n = 1'b0;
      preset_loc_n = 4'd0;
      preset_val_n = 4'd0;
      moved_n      = 1'b0;
      spawn_entry  = 1'b0;

      case (state)
         CLEAR: begin
            preset_ext_n = 1'b1;
            preset_loc_n = clr_cnt;
            clr_cnt_n    = clr_cnt + 4'd1;
            if (clr_cnt == 4'(CELLS - 1)) begin
               spawn_cnt_n = 2'd0;
               spawn_entry = 1'b1;
               state_n     = SPAWN;
            end
         end
         SPAWN: begin
            // hold while the last clear write is still on the board port
            if (!preset_ext) begin
               if (probe_cell == 4'd0) begin
                  preset_ext_n = 1'b1;
                  preset_loc_n = probe_loc;
                  preset_val_n = val;
                  state_n      = SPAWN_WAIT;
               end else if (probe == 4'(CELLS - 1)) begin
                  state_n = CHECK;
               end else begin
                  probe_n = probe + 4'd1;
               end
            end
         end
         SPAWN_WAIT: begin
            spawn_cnt_n = spawn_cnt + 2'd1;
            if (spawn_cnt == 2'd0) begin
               spawn_entry = 1'b1;
               state_n     = SPAWN;
            end else begin
               state_n = CHECK;
            end
         end
         CHECK: begin
            if (any_win) win_n = 1'b1;
            state_n = (!any_zero && !any_pair) ? OVER : IDLE;
         end
         IDLE: begin
            if (new_game) begin
               clr_cnt_n = 4'd0;
               win_n     = 1'b0;
               state_n   = CLEAR;
            end else if (move_valid && move_ready) begin
               snapshot_n = board_state;
               dir_n      = move_dir;
               settle_n   = '0;
               state_n    = MOVE;
            end
         end
         MOVE: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) state_n = COMPARE;
            else                                      settle_n = settle_cnt + SW'(1);
         end
         COMPARE: begin
            if (board_state != snapshot) begin
               moved_n     = 1'b1;
               spawn_cnt_n = 2'd1;
               spawn_entry = 1'b1;
               state_n     = SPAWN;
            end else begin
               state_n = IDLE;
            end
         end
         OVER: begin
            if (new_game) begin
               clr_cnt_n = 4'd0;
               win_n     = 1'b0;
               state_n   = CLEAR;
            end
         end
         default: state_n = CLEAR;
      endcase

      if (spawn_entry) begin
         start_n = lfsr[3:0];
         val_n   = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
         probe_n = 4'd0;
      end

      move_ready_n = (state_n == IDLE);
      busy_n       = (state_n != IDLE) && (state_n != OVER);
      game_over_n  = (state_n == OVER);
      ready_n      = (state_n == MOVE) ? 4'(4'b0001 << dir_n) : 4'd0;
   end

   // State, datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= CLEAR;
         clr_cnt           <= 4'd0;
         spawn_cnt         <= 2'd0;
         settle_cnt        <= '0;
         lfsr              <= LFSR_SEED;
         start             <= 4'd0;
         val               <= 4'd0;
         probe             <= 4'd0;
         snapshot          <= 64'd0;
         dir               <= 2'd0;
         win               <= 1'b0;
         move_ready        <= 1'b0;
         busy              <= 1'b1;
         moved             <= 1'b0;
         game_over         <= 1'b0;
         ready_to_board    <= 4'd0;
         preset_ext        <= 1'b0;
         preset_location   <= 4'd0;
         value_from_preset <= 4'd0;
      end else begin
         state             <= state_n;
         clr_cnt           <= clr_cnt_n;
         spawn_cnt         <= spawn_cnt_n;
         settle_cnt        <= settle_n;
         lfsr              <= lfsr_n;
         start             <= start_n;
         val               <= val_n;
         probe             <= probe_n;
         snapshot          <= snapshot_n;
         dir               <= dir_n;
         win               <= win_n;
         move_ready        <= move_ready_n;
         busy              <= busy_n;
         moved             <= moved_n;
         game_over         <= game_over_n;
         ready_to_board    <= ready_n;
         preset_ext        <= preset_ext_n;
         preset_location   <= preset_loc_n;
         value_from_preset <= preset_val_n;
      end
   end

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed bench for game_ctrl with a behavioural board model
// and a queue of expected per-run observations.
module tb_game_ctrl;

   logic        clk;
   logic        rst;
   logic        new_game;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic        move_ready;
   logic [3:0]  ready_to_board;
   logic        preset_ext;
   logic [3:0]  preset_location;
   logic [3:0]  value_from_preset;
   logic        busy;
   logic        moved;
   logic        win;
   logic        game_over;

   logic [63:0] board = 64'hFEDC_BA98_7654_3211;
   logic [63:0] move_result;
   logic        use_result;

   localparam logic [63:0] OVER_BOARD = 64'h8646_7535_6303_5434;

   localparam int O_TIMEOUT = 0;
   localparam int O_RTB_CYC = 1;
   localparam int O_RTB_OR  = 2;
   localparam int O_MOVED   = 3;
   localparam int O_PCYC    = 4;
   localparam int O_PRUNS   = 5;
   localparam int O_MAXRUN  = 6;
   localparam int O_OVERLAP = 7;
   localparam int O_LOW     = 8;
   localparam int O_WIN     = 9;
   localparam int O_OVER    = 10;
   localparam int O_BUSY    = 11;

   typedef struct {
      int          id;
      logic [63:0] v;
   } exp_t;

   exp_t        exp_q[$];
   logic [8:0]  clear_q[$];
   int          sp_loc_q[$];
   int          sp_val_q[$];

   int          n_checks = 0;
   int          n_errors = 0;

   int          r_pcyc, r_pruns, r_maxrun, r_rtb_cyc, r_moved, r_overlap, r_low;
   logic [3:0]  r_rtb_or;
   logic        r_timeout;

   game_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .new_game          (new_game),
      .move_valid        (move_valid),
      .move_dir          (move_dir),
      .move_ready        (move_ready),
      .board_state       (board),
      .ready_to_board    (ready_to_board),
      .preset_ext        (preset_ext),
      .preset_location   (preset_location),
      .value_from_preset (value_from_preset),
      .busy              (busy),
      .moved             (moved),
      .win               (win),
      .game_over         (game_over)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Board model: preset writes one cell, a settling move loads the scripted result
   always @(posedge clk) begin
      if (preset_ext)
         board[4*preset_location +: 4] <= value_from_preset;
      else if (ready_to_board != 4'd0 && use_result)
         board <= move_result;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int id, input logic [63:0] v);
      exp_t e;
      e.id = id;
      e.v  = v;
      exp_q.push_back(e);
   endtask

   function automatic logic [63:0] obs_of(input int id);
      case (id)
         O_TIMEOUT: return 64'(r_timeout);
         O_RTB_CYC: return 64'(r_rtb_cyc);
         O_RTB_OR:  return 64'(r_rtb_or);
         O_MOVED:   return 64'(r_moved);
         O_PCYC:    return 64'(r_pcyc);
         O_PRUNS:   return 64'(r_pruns);
         O_MAXRUN:  return 64'(r_maxrun);
         O_OVERLAP: return 64'(r_overlap);
         O_LOW:     return 64'(r_low);
         O_WIN:     return 64'(win);
         O_OVER:    return 64'(game_over);
         O_BUSY:    return 64'(busy);
         default:   return 64'hDEAD;
      endcase
   endfunction

   function automatic string name_of(input int id);
      case (id)
         O_TIMEOUT: return "timeout";
         O_RTB_CYC: return "ready_cycles";
         O_RTB_OR:  return "ready_pattern";
         O_MOVED:   return "moved_pulses";
         O_PCYC:    return "preset_cycles";
         O_PRUNS:   return "preset_runs";
         O_MAXRUN:  return "preset_max_run";
         O_OVERLAP: return "preset_ready_overlap";
         O_LOW:     return "move_ready_low_cycles";
         O_WIN:     return "win";
         O_OVER:    return "game_over";
         O_BUSY:    return "busy";
         default:   return "unknown";
      endcase
   endfunction

   task automatic drain(input string phase);
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({phase, ".", name_of(e.id)}, obs_of(e.id), e.v);
      end
   endtask

   // Clock until move_ready or game_over, logging what the DUT drove meanwhile
   task automatic run_to(input int max_cyc);
      logic prev;
      int   cur;
      prev      = preset_ext;
      cur       = preset_ext ? 1 : 0;
      r_pcyc    = 0; r_pruns = 0; r_maxrun = 0; r_rtb_cyc = 0;
      r_moved   = 0; r_overlap = 0; r_low = 0; r_rtb_or = 4'd0;
      r_timeout = 1'b1;
      sp_loc_q.delete();
      sp_val_q.delete();
      for (int i = 0; i < max_cyc; i++) begin
         step();
         move_valid = 1'b0;
         new_game   = 1'b0;
         if (preset_ext) begin
            r_pcyc++;
            if (!prev) begin
               r_pruns++;
               cur = 0;
            end
            cur++;
            if (cur > r_maxrun) r_maxrun = cur;
            if (value_from_preset != 4'd0) begin
               sp_loc_q.push_back(int'(preset_location));
               sp_val_q.push_back(int'(value_from_preset));
            end
         end
         prev = preset_ext;
         if (ready_to_board != 4'd0) begin
            r_rtb_cyc++;
            r_rtb_or = r_rtb_or | ready_to_board;
         end
         if (moved) r_moved++;
         if (preset_ext && ready_to_board != 4'd0) r_overlap++;
         if (!move_ready) r_low++;
         if (move_ready || game_over) begin
            r_timeout = 1'b0;
            break;
         end
      end
   endtask

   function automatic int count_nonzero(input logic [63:0] b);
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) if (b[4*i +: 4] != 4'd0) n++;
      return n;
   endfunction

   initial begin
      logic [3:0]  rtb_acc;
      logic [8:0]  exp_word;
      rst         = 1'b0;
      new_game    = 1'b0;
      move_valid  = 1'b0;
      move_dir    = 2'd0;
      use_result  = 1'b0;
      move_result = 64'd0;

      // Reset held for two edges
      step();
      step();
      check("reset.busy", 64'(busy), 64'd1);
      check("reset.preset_ext", 64'(preset_ext), 64'd0);
      check("reset.others", 64'({move_ready, ready_to_board, moved, win, game_over}), 64'd0);

      // Power-up clear sequence
      rst = 1'b1;
      for (int i = 0; i < 16; i++) clear_q.push_back({1'b1, 4'(i), 4'd0});
      while (clear_q.size() > 0) begin
         step();
         exp_word = clear_q.pop_front();
         check("clear.preset", 64'({preset_ext, preset_location, value_from_preset}), 64'(exp_word));
      end

      // Two initial spawns, then IDLE
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_PCYC,    64'd2);
      push_exp(O_PRUNS,   64'd2);
      push_exp(O_MAXRUN,  64'd1);
      push_exp(O_MOVED,   64'd0);
      push_exp(O_OVER,    64'd0);
      push_exp(O_BUSY,    64'd0);
      run_to(200);
      drain("powerup");
      if (sp_loc_q.size() == 2) begin
         check("powerup.distinct_locations", 64'(sp_loc_q[0] != sp_loc_q[1]), 64'd1);
         check("powerup.value0", 64'(sp_val_q[0] == 1 || sp_val_q[0] == 2), 64'd1);
         check("powerup.value1", 64'(sp_val_q[1] == 1 || sp_val_q[1] == 2), 64'd1);
      end
      check("powerup.board_tiles", 64'(count_nonzero(board)), 64'd2);

      // Changed move, direction 2
      move_result = (board == 64'h21) ? 64'h12 : 64'h21;
      use_result  = 1'b1;
      move_dir    = 2'd2;
      move_valid  = 1'b1;
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_RTB_CYC, 64'd6);
      push_exp(O_RTB_OR,  64'h4);
      push_exp(O_MOVED,   64'd1);
      push_exp(O_PCYC,    64'd1);
      push_exp(O_OVERLAP, 64'd0);
      push_exp(O_WIN,     64'd0);
      push_exp(O_OVER,    64'd0);
      run_to(100);
      drain("changed_move");
      if (sp_loc_q.size() == 1)
         check("changed_move.spawn_into_empty", 64'(move_result[4*sp_loc_q[0] +: 4]), 64'd0);

      // Unchanged move, direction 1
      use_result = 1'b0;
      move_dir   = 2'd1;
      move_valid = 1'b1;
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_RTB_CYC, 64'd6);
      push_exp(O_RTB_OR,  64'h2);
      push_exp(O_MOVED,   64'd0);
      push_exp(O_PCYC,    64'd0);
      push_exp(O_LOW,     64'd7);
      run_to(100);
      drain("unchanged_move");

      // Move producing a 2048 tile
      move_result = 64'h0000_0000_0000_00B1;
      use_result  = 1'b1;
      move_dir    = 2'd3;
      move_valid  = 1'b1;
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_RTB_OR,  64'h8);
      push_exp(O_MOVED,   64'd1);
      push_exp(O_PCYC,    64'd1);
      push_exp(O_WIN,     64'd1);
      push_exp(O_OVER,    64'd0);
      run_to(100);
      drain("win_move");

      // Win stays set across a later move
      use_result = 1'b0;
      move_dir   = 2'd0;
      move_valid = 1'b1;
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_MOVED,   64'd0);
      push_exp(O_WIN,     64'd1);
      run_to(100);
      drain("win_sticky");

      // New game clears win and reruns clear plus two spawns
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      check("new_game.win_cleared", 64'(win), 64'd0);
      check("new_game.busy", 64'(busy), 64'd1);
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_PCYC,    64'd18);
      push_exp(O_PRUNS,   64'd3);
      push_exp(O_WIN,     64'd0);
      push_exp(O_OVER,    64'd0);
      run_to(200);
      drain("new_game");

      // Move leaving only cell 5 empty with no merges possible
      move_result = OVER_BOARD;
      use_result  = 1'b1;
      move_dir    = 2'd0;
      move_valid  = 1'b1;
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_MOVED,   64'd1);
      push_exp(O_PCYC,    64'd1);
      push_exp(O_OVER,    64'd1);
      push_exp(O_WIN,     64'd0);
      push_exp(O_BUSY,    64'd0);
      run_to(100);
      drain("game_over");
      if (sp_loc_q.size() == 1)
         check("game_over.spawn_location", 64'(sp_loc_q[0]), 64'd5);

      // Moves are ignored while over
      use_result = 1'b0;
      move_dir   = 2'd2;
      move_valid = 1'b1;
      rtb_acc    = 4'd0;
      for (int i = 0; i < 4; i++) begin
         step();
         rtb_acc = rtb_acc | ready_to_board;
      end
      move_valid = 1'b0;
      check("over.move_ignored", 64'(rtb_acc), 64'd0);
      check("over.still_over", 64'({game_over, move_ready}), 64'h2);

      // New game from OVER
      new_game = 1'b1;
      step();
      new_game = 1'b0;
      check("over_new_game.game_over", 64'(game_over), 64'd0);
      check("over_new_game.busy", 64'(busy), 64'd1);
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_PCYC,    64'd18);
      push_exp(O_OVER,    64'd0);
      run_to(200);
      drain("over_new_game");

      // Reset during the third settle cycle of a move
      use_result = 1'b0;
      move_dir   = 2'd1;
      move_valid = 1'b1;
      step();
      move_valid = 1'b0;
      check("reset_mid_move.ready_first", 64'(ready_to_board), 64'h2);
      step();
      step();
      check("reset_mid_move.ready_third", 64'(ready_to_board), 64'h2);
      rst = 1'b0;
      step();
      check("reset_mid_move.outputs", 64'({ready_to_board, preset_ext, busy, move_ready}), 64'h2);
      rst = 1'b1;
      step();
      check("reset_mid_move.clear_restart", 64'({preset_ext, preset_location, value_from_preset}), 64'h100);
      push_exp(O_TIMEOUT, 64'd0);
      push_exp(O_PCYC,    64'd17);
      push_exp(O_OVER,    64'd0);
      run_to(200);
      drain("reset_mid_move");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
